// File: rtl/instr_encoder.sv
// Data-processing instruction encoder: accepts one request at a time, encodes it
// into a 32-bit word and writes it to sequential instruction-memory addresses.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic              req_s,
  input  logic              req_imm,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rn,
  input  logic [11:0]       req_src2,
  input  logic              clear,
  input  logic              mem_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_illegal,
  output logic              full,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {IDLE, ENC, WRITE} state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST     = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  state_t      state;
  logic        accept;
  logic [3:0]  op_p0;
  logic        s_p0;
  logic        imm_p0;
  logic [3:0]  rd_p0;
  logic [3:0]  rn_p0;
  logic [11:0] src2_p0;

  function automatic logic is_illegal(input logic [3:0] op, input logic s, input logic imm);
    logic bad;
    bad = 1'b0;
    if (op > 4'd9) bad = 1'b1;
    if ((op == 4'd5 || op == 4'd6) && (imm || s)) bad = 1'b1;
    if ((op == 4'd7 || op == 4'd8) && (!imm || s)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [5:0] funct_of(input logic [3:0] op, input logic s, input logic imm);
    logic [5:0] f;
    case (op)
      4'd0:    f = {imm, 4'b0000, s};
      4'd1:    f = {imm, 4'b0010, s};
      4'd2:    f = {imm, 4'b0100, s};
      4'd3:    f = {imm, 4'b1100, s};
      4'd4:    f = {imm, 4'b1010, 1'b1};
      4'd5:    f = 6'b000010;
      4'd6:    f = 6'b011010;
      4'd7:    f = 6'b111010;
      4'd8:    f = 6'b111110;
      4'd9:    f = 6'b010010;
      default: f = 6'b000000;
    endcase
    return f;
  endfunction

  // MOV, MVN and B have no first operand, so Rn is encoded as zero.
  function automatic logic [31:0] encode(input logic [3:0] op, input logic s, input logic imm,
                                         input logic [3:0] rd, input logic [3:0] rn,
                                         input logic [11:0] src2);
    logic [3:0] rn_eff;
    rn_eff = (op == 4'd7 || op == 4'd8 || op == 4'd9) ? 4'b0000 : rn;
    return {4'b1110, 2'b00, funct_of(op, s, imm), rn_eff, rd, src2};
  endfunction

  assign accept = req_valid && req_ready;

  // Stage p0: request capture; later input changes do not disturb these.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= req_op;
      s_p0    <= req_s;
      imm_p0  <= req_imm;
      rd_p0   <= req_rd;
      rn_p0   <= req_rn;
      src2_p0 <= req_src2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= BASE;
      mem_wdata   <= '0;
      err_illegal <= 1'b0;
      full        <= 1'b0;
      word_count  <= '0;
    end else if (clear) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= BASE;
      err_illegal <= 1'b0;
      full        <= 1'b0;
      word_count  <= '0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= ENC;
            req_ready   <= 1'b0;
            err_illegal <= is_illegal(req_op, req_s, req_imm);
          end else begin
            req_ready <= !full;
          end
        end
        ENC: begin
          if (is_illegal(op_p0, s_p0, imm_p0)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            state     <= WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= encode(op_p0, s_p0, imm_p0, rd_p0, rn_p0, src2_p0);
          end
        end
        WRITE: begin
          if (!mem_stall) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            word_count <= word_count + CNT_ONE;
            // The top address is written once; afterwards the encoder parks until cleared.
            if (mem_addr == LAST) begin
              full      <= 1'b1;
              req_ready <= 1'b0;
            end else begin
              mem_addr  <= mem_addr + ADDR_ONE;
              req_ready <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= !full;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder built with ADDR_W=2 so that the full/clear
// behaviour is reachable after four writes.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_s;
  logic        req_imm;
  logic [3:0]  req_rd;
  logic [3:0]  req_rn;
  logic [11:0] req_src2;
  logic        clear;
  logic        mem_stall;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        err_illegal;
  logic        full;
  logic [2:0]  word_count;

  int total = 0;
  int passed = 0;

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_s(req_s), .req_imm(req_imm), .req_rd(req_rd),
    .req_rn(req_rn), .req_src2(req_src2), .clear(clear), .mem_stall(mem_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err_illegal(err_illegal), .full(full), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic s, input logic imm,
                       input logic [3:0] rd, input logic [3:0] rn, input logic [11:0] src2);
    req_op = op; req_s = s; req_imm = imm; req_rd = rd; req_rn = rn; req_src2 = src2;
    req_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; mem_stall = 1'b0; req_valid = 1'b0;
    req_op = 4'd0; req_s = 1'b0; req_imm = 1'b0; req_rd = 4'd0; req_rn = 4'd0; req_src2 = 12'd0;
    tick(); tick();
    rst_n = 1'b1;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== 2'd0) $display("FAIL reset_addr got %0d want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", mem_wdata); else passed++;
    total++; if (err_illegal !== 1'b0 || full !== 1'b0) $display("FAIL reset_err_full got %b%b want 00", err_illegal, full); else passed++;
    total++; if (word_count !== 3'd0) $display("FAIL reset_count got %0d want 0", word_count); else passed++;
  endtask

  task automatic test_add();
    drive(4'd2, 1'b1, 1'b1, 4'd3, 4'd1, 12'h005);
    tick();
    req_valid = 1'b0; req_op = 4'd12; req_rd = 4'hF; req_rn = 4'hF; req_src2 = 12'hFFF;
    total++; if (req_ready !== 1'b0 || mem_we !== 1'b0 || err_illegal !== 1'b0)
      $display("FAIL add_enc got ready=%b we=%b err=%b want 0 0 0", req_ready, mem_we, err_illegal); else passed++;
    tick();
    total++; if (mem_we !== 1'b1 || mem_addr !== 2'd0) $display("FAIL add_write got we=%b addr=%0d want 1 0", mem_we, mem_addr); else passed++;
    total++; if (mem_wdata !== 32'hE2913005) $display("FAIL add_word got %h want E2913005", mem_wdata); else passed++;
    tick();
    total++; if (mem_we !== 1'b0 || word_count !== 3'd1 || mem_addr !== 2'd1 || req_ready !== 1'b1)
      $display("FAIL add_done got we=%b cnt=%0d addr=%0d ready=%b want 0 1 1 1", mem_we, word_count, mem_addr, req_ready); else passed++;
  endtask

  task automatic test_cmp();
    drive(4'd4, 1'b0, 1'b0, 4'd0, 4'd2, 12'h001);
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (mem_we !== 1'b1 || mem_addr !== 2'd1) $display("FAIL cmp_write got we=%b addr=%0d want 1 1", mem_we, mem_addr); else passed++;
    total++; if (mem_wdata !== 32'hE1520001) $display("FAIL cmp_word got %h want E1520001", mem_wdata); else passed++;
    tick();
    total++; if (word_count !== 3'd2) $display("FAIL cmp_count got %0d want 2", word_count); else passed++;
  endtask

  task automatic test_illegal_mul();
    drive(4'd5, 1'b0, 1'b1, 4'd1, 4'd2, 12'h000);
    tick();
    req_valid = 1'b0;
    total++; if (err_illegal !== 1'b1 || mem_we !== 1'b0) $display("FAIL mul_err got err=%b we=%b want 1 0", err_illegal, mem_we); else passed++;
    tick();
    total++; if (err_illegal !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL mul_after got err=%b we=%b ready=%b want 0 0 1", err_illegal, mem_we, req_ready); else passed++;
    total++; if (mem_addr !== 2'd2 || word_count !== 3'd2) $display("FAIL mul_addr got addr=%0d cnt=%0d want 2 2", mem_addr, word_count); else passed++;
    tick();
    total++; if (mem_we !== 1'b0) $display("FAIL mul_nowrite got %b want 0", mem_we); else passed++;
  endtask

  task automatic test_stall();
    drive(4'd7, 1'b0, 1'b1, 4'd5, 4'd9, 12'h0FF);
    tick();
    req_valid = 1'b0;
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (mem_we !== 1'b1 || mem_addr !== 2'd2 || mem_wdata !== 32'hE3A050FF || req_ready !== 1'b0)
        $display("FAIL stall_hold%0d got we=%b addr=%0d word=%h ready=%b want 1 2 E3A050FF 0", i, mem_we, mem_addr, mem_wdata, req_ready);
      else passed++;
    end
    mem_stall = 1'b0;
    tick();
    total++; if (mem_we !== 1'b0 || mem_addr !== 2'd3 || word_count !== 3'd3)
      $display("FAIL stall_done got we=%b addr=%0d cnt=%0d want 0 3 3", mem_we, mem_addr, word_count); else passed++;
  endtask

  task automatic test_full_clear();
    drive(4'd3, 1'b0, 1'b0, 4'd1, 4'd2, 12'h003);
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (mem_we !== 1'b1 || mem_addr !== 2'd3 || mem_wdata !== 32'hE1821003)
      $display("FAIL orr_write got we=%b addr=%0d word=%h want 1 3 E1821003", mem_we, mem_addr, mem_wdata); else passed++;
    tick();
    total++; if (full !== 1'b1 || req_ready !== 1'b0 || word_count !== 3'd4 || mem_addr !== 2'd3)
      $display("FAIL full_set got full=%b ready=%b cnt=%0d addr=%0d want 1 0 4 3", full, req_ready, word_count, mem_addr); else passed++;
    drive(4'd2, 1'b0, 1'b0, 4'd1, 4'd1, 12'h001);
    tick(); tick(); tick();
    total++; if (mem_we !== 1'b0 || err_illegal !== 1'b0 || word_count !== 3'd4 || req_ready !== 1'b0)
      $display("FAIL full_block got we=%b err=%b cnt=%0d ready=%b want 0 0 4 0", mem_we, err_illegal, word_count, req_ready); else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0; req_valid = 1'b0;
    total++; if (mem_addr !== 2'd0 || full !== 1'b0 || word_count !== 3'd0 || req_ready !== 1'b1)
      $display("FAIL clear_full got addr=%0d full=%b cnt=%0d ready=%b want 0 0 0 1", mem_addr, full, word_count, req_ready); else passed++;
  endtask

  task automatic test_clear_priority();
    drive(4'd2, 1'b0, 1'b0, 4'd1, 4'd1, 12'h001);
    clear = 1'b1;
    tick();
    clear = 1'b0; req_valid = 1'b0;
    total++; if (req_ready !== 1'b1 || err_illegal !== 1'b0) $display("FAIL clrpri_ready got %b want 1", req_ready); else passed++;
    tick();
    total++; if (mem_we !== 1'b0 || word_count !== 3'd0) $display("FAIL clrpri_nowrite got we=%b cnt=%0d want 0 0", mem_we, word_count); else passed++;
  endtask

  task automatic test_branch();
    drive(4'd9, 1'b0, 1'b0, 4'd0, 4'd7, 12'hABC);
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'hE1200ABC)
      $display("FAIL b_write got we=%b addr=%0d word=%h want 1 0 E1200ABC", mem_we, mem_addr, mem_wdata); else passed++;
    tick();
    total++; if (word_count !== 3'd1 || mem_addr !== 2'd1) $display("FAIL b_done got cnt=%0d addr=%0d want 1 1", word_count, mem_addr); else passed++;
  endtask

  task automatic test_clear_write();
    drive(4'd1, 1'b0, 1'b0, 4'd2, 4'd3, 12'h004);
    tick();
    req_valid = 1'b0; mem_stall = 1'b1;
    tick();
    total++; if (mem_we !== 1'b1 || mem_wdata !== 32'hE0432004) $display("FAIL sub_write got we=%b word=%h want 1 E0432004", mem_we, mem_wdata); else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0; mem_stall = 1'b0;
    total++; if (mem_we !== 1'b0 || mem_addr !== 2'd0 || word_count !== 3'd0 || req_ready !== 1'b1)
      $display("FAIL clrw got we=%b addr=%0d cnt=%0d ready=%b want 0 0 0 1", mem_we, mem_addr, word_count, req_ready); else passed++;
  endtask

  task automatic test_reset_write();
    drive(4'd0, 1'b1, 1'b0, 4'd4, 4'd6, 12'h123);
    tick();
    req_valid = 1'b0; mem_stall = 1'b1;
    tick(); tick();
    total++; if (mem_we !== 1'b1 || mem_wdata !== 32'hE0164123) $display("FAIL and_hold got we=%b word=%h want 1 E0164123", mem_we, mem_wdata); else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_stall = 1'b0;
    total++; if (mem_we !== 1'b0 || mem_wdata !== 32'h0 || mem_addr !== 2'd0 || req_ready !== 1'b1)
      $display("FAIL rstw got we=%b word=%h addr=%0d ready=%b want 0 0 0 1", mem_we, mem_wdata, mem_addr, req_ready); else passed++;
    total++; if (err_illegal !== 1'b0 || full !== 1'b0 || word_count !== 3'd0)
      $display("FAIL rstw_flags got err=%b full=%b cnt=%0d want 0 0 0", err_illegal, full, word_count); else passed++;
  endtask

  task automatic test_back_to_back();
    drive(4'd12, 1'b0, 1'b0, 4'd1, 4'd1, 12'h000);
    tick();
    total++; if (err_illegal !== 1'b1) $display("FAIL op12_err got %b want 1", err_illegal); else passed++;
    tick();
    drive(4'd8, 1'b1, 1'b1, 4'd1, 4'd0, 12'h000);
    tick();
    total++; if (err_illegal !== 1'b1) $display("FAIL mvns_err got %b want 1", err_illegal); else passed++;
    tick();
    drive(4'd6, 1'b0, 1'b0, 4'd2, 4'd3, 12'h041);
    tick();
    req_valid = 1'b0;
    total++; if (err_illegal !== 1'b0) $display("FAIL lsr_err got %b want 0", err_illegal); else passed++;
    tick();
    total++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'hE1A32041)
      $display("FAIL lsr_write got we=%b addr=%0d word=%h want 1 0 E1A32041", mem_we, mem_addr, mem_wdata); else passed++;
    tick();
    total++; if (word_count !== 3'd1) $display("FAIL lsr_count got %0d want 1", word_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_illegal_mul();
    test_stall();
    test_full_clear();
    test_clear_priority();
    test_branch();
    test_clear_write();
    test_reset_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters: ADDR_W, default 8, instruction-memory address width; BASE_ADDR, default 0, first write address.
REQ-002 Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  encode request present.
- req_ready  out  1  encoder can accept a request.
- req_op  in  4  operation code: 0 AND, 1 SUB, 2 ADD, 3 ORR, 4 CMP, 5 MUL, 6 LSR, 7 MOV, 8 MVN, 9 B.
- req_s  in  1  set-flags request.
- req_imm  in  1  src2 is an immediate.
- req_rd  in  4  destination register.
- req_rn  in  4  first source register.
- req_src2  in  12  immediate or register/shift field.
- clear  in  1  synchronous flush; address returns to BASE_ADDR.
- mem_stall  in  1  memory cannot take a write this cycle.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction word.
- err_illegal  out  1  one-cycle pulse on a rejected request.
- full  out  1  last address has been written.
- word_count  out  ADDR_W+1  number of words written since reset or clear.

Function
REQ-003 Word format: [31:28]=4'b1110, [27:26]=2'b00, [25:20]=funct, [19:16]=Rn, [15:12]=Rd, [11:0]=req_src2.
REQ-004 Funct by op: AND {imm,0000,s}; SUB {imm,0010,s}; ADD {imm,0100,s}; ORR {imm,1100,s}; CMP {imm,1010,1}; MUL 000010; LSR 011010; MOV 111010; MVN 111110; B 010010.
REQ-005 CMP forces S=1 regardless of req_s.
REQ-006 MOV, MVN and B encode Rn as 4'b0000.
REQ-007 Illegal requests: op 10..15; MUL or LSR with req_imm=1 or req_s=1; MOV or MVN with req_imm=0 or req_s=1.
REQ-008 FSM states: IDLE, ENC, WRITE.
- IDLE: req_ready=1 unless full=1. On req_valid&req_ready, register all req_* fields and go to ENC.
- ENC: req_ready=0. If the request is illegal, pulse err_illegal and return to IDLE. Otherwise latch mem_wdata and go to WRITE.
- WRITE: req_ready=0; mem_we=1, with mem_addr and mem_wdata held stable. If mem_stall=1, stay in WRITE. Otherwise increment the address and word_count, then return to IDLE.
REQ-009 Latency: request accepted at edge N; err_illegal high during cycle N+1; mem_we first high in cycle N+2. Maximum throughput is one word per 3 cycles.
REQ-010 Address handling: after a write to address 2^ADDR_W-1, set full=1 and hold mem_addr (no wrap). While full=1, req_ready stays 0.
REQ-011 clear=1 in any state:
- next state IDLE, mem_addr=BASE_ADDR, word_count=0, full=0.
- any in-progress write is aborted: mem_we=0 in the next cycle.
- clear has priority over req_valid in the same cycle.
REQ-012 mem_stall is ignored outside WRITE.
REQ-013 Registered request fields are not affected by input changes after acceptance.

Reset
REQ-014 rst_n=0 at a clock edge, from any state:
- state IDLE.
- req_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
- err_illegal=0, full=0, word_count=0.
REQ-015 rst_n has priority over clear and over all requests.

Verification
REQ-016 ADD: op=2, s=1, imm=1, rd=3, rn=1, src2=0x005 -> mem_we in cycle N+2 with mem_addr=0 and mem_wdata=0xE2913005; word_count=1 afterwards.
REQ-017 CMP: op=4, s=0, imm=0, rn=2, rd=0, src2=0x001, issued as the second request -> mem_addr=1, mem_wdata=0xE1520001.
REQ-018 Illegal MUL: op=5, imm=1 -> err_illegal high for exactly one cycle at N+1, no mem_we, mem_addr and word_count unchanged, req_ready=1 at N+2.
REQ-019 Stall: mem_stall=1 for 2 cycles during WRITE -> mem_we high for 3 cycles with constant mem_addr and mem_wdata, req_ready=0 throughout, a single address increment.
REQ-020 Full then clear: ADDR_W=2, four legal requests -> full=1, req_ready=0, word_count=4. A further req_valid is not accepted. Pulse clear -> mem_addr=0, full=0, word_count=0, req_ready=1.
REQ-021 Reset during WRITE: with mem_stall=1 holding WRITE, rst_n=0 for one edge -> mem_we=0 on the next cycle and all outputs at their REQ-014 values.
